axi_slave_resp_pop_fsm: RTL and testbench

Drain side of the AXI slave write-response path. It reads queued write-response entries {BID, BRESP} from the response buffer that the Push FSM fills, and presents them on the AXI B channel with a VALID/READY handshake. It issues one decrement pulse per completed handshake to the shared Up_Down_Counter, so the counter's occupancy value stays the single source of truth for buffer fill level.

---
 rtl/axi_slave_resp_pop_fsm_pkg.sv | 29 ++
 rtl/axi_slave_resp_pop_fsm_if.sv | 22 ++
 rtl/axi_slave_resp_pop_fsm.sv | 115 +++++++++++
 tb/tb_axi_slave_resp_pop_fsm.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_resp_pop_fsm_pkg.sv
// ---------------------------------------------------------------------------
// axi_resp_pop_pkg
// Shared types for the AXI slave write-response drain path:
//   state_t      - pop FSM state encoding (also exported on the debug port)
//   OKAY..DECERR - AXI BRESP codes
//   resp_entry_t - one response buffer entry {BID, BRESP}
// ---------------------------------------------------------------------------
package axi_resp_pop_pkg;

   localparam int DEF_ID_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_REQ  = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef struct packed {
      logic [DEF_ID_W-1:0] id;
      logic [1:0]          resp;
   } resp_entry_t;

endpackage

// File: rtl/axi_slave_resp_pop_fsm_if.sv
// ---------------------------------------------------------------------------
// axi_slave_resp_pop_fsm_if
// AXI write-response (B) channel.
//   BVALID/BID/BRESP : driven by the slave (modport slave)
//   BREADY           : driven by the master (modport master)
// Handshake: a response transfers on every rising edge where BVALID and
// BREADY are both high. Once BVALID is raised, BVALID, BID and BRESP hold
// stable until that transfer; BVALID never depends on BREADY.
// ---------------------------------------------------------------------------
interface axi_slave_resp_pop_fsm_if
   import axi_resp_pop_pkg::*;
#(
   parameter int ID_W = DEF_ID_W
);
   logic            BVALID;
   logic            BREADY;
   logic [ID_W-1:0] BID;
   logic [1:0]      BRESP;

   modport slave  (output BVALID, output BID, output BRESP, input BREADY);
   modport master (input BVALID, input BID, input BRESP, output BREADY);
endinterface

// File: rtl/axi_slave_resp_pop_fsm.sv
// ---------------------------------------------------------------------------
// axi_slave_resp_pop_fsm
// Drains {BID, BRESP} entries from the write-response buffer and presents
// them on the AXI B channel. Each completed handshake emits one decrement
// pulse to the shared occupancy counter.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   count_i      - buffer occupancy from the up/down counter
//   rd_en_o      - buffer read strobe (data returns one cycle later)
//   rd_addr_o    - buffer read pointer, wraps DEPTH-1 -> 0
//   rd_data_i    - {BID, BRESP} returned by the buffer
//   count_dec_o  - one-cycle decrement pulse on each B handshake
//   b            - B channel (slave modport)
//   state_o      - debug view of the FSM state
//   err_cnt_o    - saturating SLVERR/DECERR count (only when
//                  RESP_POP_ERR_CNT_EN is defined)
//
// Optional build macro: RESP_POP_ERR_CNT_EN
// ---------------------------------------------------------------------------
module axi_slave_resp_pop_fsm
   import axi_resp_pop_pkg::*;
#(
   parameter  int DEPTH  = 10,
   parameter  int ID_W   = DEF_ID_W,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CNT_W-1:0]    count_i,
   output logic                rd_en_o,
   output logic [ADDR_W-1:0]   rd_addr_o,
   input  logic [ID_W+1:0]     rd_data_i,
   output logic                count_dec_o,
   axi_slave_resp_pop_fsm_if.slave b,
   output state_t              state_o
`ifdef RESP_POP_ERR_CNT_EN
   ,
   output logic [7:0]          err_cnt_o
`endif
);

   state_t              state;
   logic                handshake;
   logic [ADDR_W-1:0]   addr_next;

   // The decrement must land in the handshake cycle itself, so it is the
   // only combinational output. Gating with rst makes a reset that lands on
   // a pending response retire nothing.
   always_comb begin
      handshake = b.BVALID && b.BREADY && !rst;
      addr_next = (rd_addr_o == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr_o + 1'b1;
   end

   assign count_dec_o = handshake;
   assign state_o     = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rd_en_o   <= 1'b0;
         rd_addr_o <= '0;
         b.BVALID  <= 1'b0;
         b.BID     <= '0;
         b.BRESP   <= OKAY;
      end else begin
         rd_en_o <= 1'b0;
         case (state)
            IDLE: begin
               if (count_i != '0) begin
                  state   <= RD_REQ;
                  rd_en_o <= 1'b1;
               end
            end
            RD_REQ: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               b.BID    <= rd_data_i[ID_W+1:2];
               b.BRESP  <= rd_data_i[1:0];
               b.BVALID <= 1'b1;
               state    <= RESP;
            end
            RESP: begin
               if (handshake) begin
                  b.BVALID  <= 1'b0;
                  rd_addr_o <= addr_next;
                  // count_i still includes the entry being retired here,
                  // so more than one means another entry is waiting.
                  if (count_i > CNT_W'(1)) begin
                     state   <= RD_REQ;
                     rd_en_o <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RESP_POP_ERR_CNT_EN
   // BRESP[1] set means SLVERR or DECERR.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_o <= '0;
      end else if (handshake && b.BRESP[1] && (err_cnt_o != 8'hFF)) begin
         err_cnt_o <= err_cnt_o + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axi_slave_resp_pop_fsm.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_resp_pop_fsm
// Directed bench for axi_slave_resp_pop_fsm with a response-buffer model,
// an occupancy-counter model and an in-order scoreboard on the B channel.
// Optional build macro: RESP_POP_ERR_CNT_EN
// ---------------------------------------------------------------------------
module tb_axi_slave_resp_pop_fsm;
   import axi_resp_pop_pkg::*;

   localparam int DEPTH  = 10;
   localparam int ID_W   = DEF_ID_W;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int EW     = ID_W + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [CNT_W-1:0]  count_i = '0;
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [EW-1:0]     rd_data_i = '0;
   logic              count_dec_o;
   state_t            state_o;
`ifdef RESP_POP_ERR_CNT_EN
   logic [7:0]        err_cnt_o;
`endif

   axi_slave_resp_pop_fsm_if #(.ID_W(ID_W)) b_if ();

   axi_slave_resp_pop_fsm #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .count_i     (count_i),
      .rd_en_o     (rd_en_o),
      .rd_addr_o   (rd_addr_o),
      .rd_data_i   (rd_data_i),
      .count_dec_o (count_dec_o),
      .b           (b_if.slave),
      .state_o     (state_o)
`ifdef RESP_POP_ERR_CNT_EN
      ,
      .err_cnt_o   (err_cnt_o)
`endif
   );

   // ---------------- environment models ----------------
   resp_entry_t mem [DEPTH];
   int          wr_ptr   = 0;
   int          push_amt = 0;
   int          cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rd_en_o) rd_data_i <= mem[rd_addr_o];
   end

   always @(posedge clk) begin
      if (rst) count_i <= '0;
      else     count_i <= count_i + CNT_W'(push_amt) - CNT_W'(count_dec_o);
   end

   // ---------------- scoreboard ----------------
   logic [EW-1:0]     exp_q [$];
   logic [ADDR_W-1:0] addr_q [$];
   int                hs_cyc_q [$];
   int                dec_cnt  = 0;
   int                n_checks = 0;
   int                n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!rst && count_dec_o) begin
         dec_cnt++;
         hs_cyc_q.push_back(cyc);
      end
      if (!rst && rd_en_o) addr_q.push_back(rd_addr_o);
      if (!rst && b_if.BVALID && b_if.BREADY) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_resp", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("sb_bid", b_if.BID, e[EW-1:2]);
            check("sb_bresp", b_if.BRESP, e[1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_entry(input logic [ID_W-1:0] id, input logic [1:0] resp);
      resp_entry_t ent;
      ent.id   = id;
      ent.resp = resp;
      mem[wr_ptr] = ent;
      exp_q.push_back({id, resp});
      wr_ptr   = (wr_ptr == DEPTH - 1) ? 0 : wr_ptr + 1;
      push_amt = push_amt + 1;
   endtask

   function automatic logic [1:0] resp_of(input int i, input int mode);
      logic [1:0] pat [4];
      pat[0] = OKAY; pat[1] = SLVERR; pat[2] = DECERR; pat[3] = EXOKAY;
      case (mode)
         0:       resp_of = 2'(i % 4);
         1:       resp_of = pat[i % 4];
         default: resp_of = SLVERR;
      endcase
   endfunction

   task automatic wait_bvalid(input string tag);
      int n = 0;
      while (!b_if.BVALID && n < 30) begin
         @(negedge clk);
         n++;
      end
      check(tag, b_if.BVALID, 1);
   endtask

   // Push n entries (one per cycle while there is room) and wait for drain.
   task automatic run_stream(input int n, input int mode, input string tag);
      int g;
      for (int i = 0; i < n; i++) begin
         g = 0;
         while (count_i >= CNT_W'(DEPTH) && g < 100) begin
            tick();
            g++;
         end
         push_entry(ID_W'(i), resp_of(i, mode));
         tick();
         push_amt = 0;
      end
      g = 0;
      while ((exp_q.size() != 0 || b_if.BVALID) && g < 2000) begin
         tick();
         g++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      b_if.BREADY = 1'b0;
      push_amt = 0;
      tick();
      tick();
      rst = 1'b0;
      wr_ptr = 0;
      exp_q.delete();
      addr_q.delete();
      hs_cyc_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int bit_any;
      int dec0;
      logic [ADDR_W-1:0] a;

      b_if.BREADY = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("reset_bvalid", b_if.BVALID, 0);
      check("reset_rd_en", rd_en_o, 0);
      check("reset_rd_addr", rd_addr_o, 0);
      check("reset_dec", count_dec_o, 0);
      check("reset_bid", b_if.BID, 0);
      check("reset_bresp", b_if.BRESP, 0);
      check("reset_state", state_o, IDLE);

      // Empty guard
      tick();
      rst = 1'b0;
      b_if.BREADY = 1'b1;
      bit_any = 0;
      repeat (20) begin
         @(negedge clk);
         if (rd_en_o || b_if.BVALID || count_dec_o) bit_any = 1;
      end
      check("empty_no_activity", bit_any, 0);
      check("empty_state", state_o, IDLE);

      // Single entry, BREADY held high
      tick();
      push_entry(4'h3, OKAY);
      tick();
      push_amt = 0;
      @(negedge clk);
      check("single_c0_rd_en", rd_en_o, 0);
      @(negedge clk);
      check("single_c1_rd_en", rd_en_o, 1);
      check("single_c1_rd_addr", rd_addr_o, 0);
      @(negedge clk);
      check("single_c2_bvalid", b_if.BVALID, 0);
      @(negedge clk);
      check("single_c3_bvalid", b_if.BVALID, 1);
      check("single_c3_bid", b_if.BID, 4'h3);
      check("single_c3_bresp", b_if.BRESP, OKAY);
      check("single_c3_dec", count_dec_o, 1);
      @(negedge clk);
      check("single_c4_bvalid", b_if.BVALID, 0);
      check("single_c4_dec", count_dec_o, 0);
      check("single_c4_state", state_o, IDLE);
      check("single_c4_rd_addr", rd_addr_o, 1);

      // Backpressure: 5 stalled cycles
      tick();
      b_if.BREADY = 1'b0;
      push_entry(4'hA, SLVERR);
      tick();
      push_amt = 0;
      dec0 = dec_cnt;
      @(negedge clk);
      wait_bvalid("bp_bvalid_seen");
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         check("bp_hold_bvalid", b_if.BVALID, 1);
         check("bp_hold_bid", b_if.BID, 4'hA);
         check("bp_hold_bresp", b_if.BRESP, SLVERR);
         check("bp_hold_no_dec", count_dec_o, 0);
      end
      tick();
      b_if.BREADY = 1'b1;
      @(negedge clk);
      check("bp_release_dec", count_dec_o, 1);
      tick();
      @(negedge clk);
      check("bp_after_bvalid", b_if.BVALID, 0);
      check("bp_one_dec", dec_cnt - dec0, 1);

      // Reset while a response is pending (BREADY rises with rst)
      tick();
      b_if.BREADY = 1'b0;
      push_entry(4'h5, OKAY);
      tick();
      push_amt = 0;
      @(negedge clk);
      wait_bvalid("rst_bvalid_seen");
      check("rst_pre_addr", rd_addr_o, 2);
      dec0 = dec_cnt;
      tick();
      rst = 1'b1;
      b_if.BREADY = 1'b1;
      @(negedge clk);
      check("rst_cycle_no_dec", count_dec_o, 0);
      tick();
      @(negedge clk);
      check("rst_bvalid", b_if.BVALID, 0);
      check("rst_rd_addr", rd_addr_o, 0);
      check("rst_state", state_o, IDLE);
      check("rst_no_dec", dec_cnt - dec0, 0);
      tick();
      rst = 1'b0;
      wr_ptr = 0;
      exp_q.delete();
      addr_q.delete();
      hs_cyc_q.delete();

      // Stream of 12 through a 10-deep buffer
      run_stream(12, 0, "stream_drained");
      check("stream_rd_count", addr_q.size(), 12);
      for (int i = 0; i < 12; i++) begin
         a = (i < addr_q.size()) ? addr_q[i] : '1;
         check("stream_rd_addr", a, i % DEPTH);
      end
      check("stream_hs_count", hs_cyc_q.size(), 12);
      for (int i = 1; i < 12; i++) begin
         if (i < hs_cyc_q.size()) check("stream_gap", hs_cyc_q[i] - hs_cyc_q[i-1], 3);
      end
      check("stream_end_state", state_o, IDLE);

`ifdef RESP_POP_ERR_CNT_EN
      do_reset();
      @(negedge clk);
      check("err_reset", err_cnt_o, 0);
      tick();
      b_if.BREADY = 1'b1;
      run_stream(4, 1, "err_mix_drained");
      check("err_mix_count", err_cnt_o, 2);
      run_stream(300, 2, "err_sat_drained");
      check("err_saturated", err_cnt_o, 255);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
